psg_channel: RTL and testbench
==============================

// Module: psg_channel
// PURPOSE
//  AY-style sound channel and consumer of the psg_en strobe (clk_peripheral/16).
//  Holds tone, noise, mixer and volume registers written by the CPU-side decoder.
//  Advances a tone square-wave counter and a 17-bit noise LFSR only on psg_en.
//  Drives a registered 4-bit level to the audio mixer.
// PARAMETERS
//  TONE_W     12        tone period width (registers 0/1)
//  NOISE_W    5         noise period width (register 2)
//  VOL_W      4         volume / audio_out width
//  LFSR_SEED  17'h00001 noise LFSR value after reset (must be non-zero)
// PORTS
//  clk_peripheral in  1        peripheral clock; every flop is on its rising edge
//  reset_n        in  1        asynchronous, active-low reset
//  psg_en         in  1        1-cycle tick from the psg divider, every 16 clocks
//  wr_en          in  1        register write strobe, one cycle per write
//  wr_addr        in  3        register address
//  wr_data        in  8        write data
//  rd_addr        in  3        readback address
//  rd_data        out 8        readback data, registered
//  tone_out       out 1        raw tone square wave
//  noise_out      out 1        raw noise bit, lfsr[0]
//  audio_out      out VOL_W    mixed, volume-scaled level, registered
// BEHAVIOUR
//  Reset: all registers=0, tone counter=0, noise counter=0, noise prescaler=0,
//    tone_out=0, lfsr=LFSR_SEED, noise_out=LFSR_SEED[0], rd_data=0, audio_out=0.
//  Register map (write):
//    0 tone[7:0]; 1 tone[11:8]=wr_data[3:0]; 2 noise_p=wr_data[4:0];
//    3 mix: bit0 tone_dis, bit1 noise_dis (1=disable); 4 vol=wr_data[3:0].
//  Writes to 5..7 are ignored. Unused data bits are dropped.
//  Readback: rd_data <= zero-extended register at rd_addr, 1-cycle latency;
//    addresses 5..7 read as 8'h00.
//  A write takes effect the cycle after wr_en. If a write lands in a psg_en cycle,
//    that cycle's counter compare uses the old value.
//  Tone, per psg_en:
//    eff = (tone==0) ? 1 : tone.
//    If tcnt+1 >= eff: tcnt<=0 and tone_out toggles; else tcnt<=tcnt+1.
//    Half-period = eff ticks, so full period = 2*eff*16 clocks.
//    Writing a period below the current count wraps at the next tick; the counter
//    is never left running to its maximum value.
//  Noise:
//    A 1-bit prescaler toggles on each psg_en, so noise advances every 2nd psg_en.
//    On an advancing tick: neff = (noise_p==0) ? 1 : noise_p.
//    ncnt wraps under the same rule as tone. On wrap:
//      lfsr <= {lfsr[0]^lfsr[3], lfsr[16:1]}.
//    LFSR state 0 is unreachable and is never forced.
//  Mixer: on = (tone_out|tone_dis) & (noise_out|noise_dis).
//    audio_out <= on ? vol : 0, updated every clock with 1-cycle latency.
//    With both disables set, audio_out holds vol (DC level, used for sample playback).
//  With no psg_en, all counters, tone_out and lfsr hold; register writes still apply.
//  reset_n low mid-operation returns everything to reset values immediately.
//  Operation resumes on the first psg_en after reset_n deasserts.
// TESTING
//  1 Reset, then tone=1, mix=2'b10, vol=F, 16-clk psg_en -> tone_out toggles every 16
//    clocks; audio_out alternates F/0.
//  2 tone=0 vs tone=1 -> identical waveforms.
//    tone=12'hFFF -> toggle every 4095 ticks.
//    tone=100 at tcnt=50, then tone=10 -> wrap on the next tick.
//  3 noise_p=1, mix=2'b01, vol=8 -> LFSR steps every 2nd psg_en; first outputs match a
//    reference model from seed 1; audio_out = 8 when lfsr[0]=1, else 0.
//  4 mix=2'b11, vol=5 -> audio_out=5 constant.
//    vol change -> audio_out follows 2 clocks after wr_en.
//  5 Write all regs; read back -> zero-extended values (reg1=0x0X, reg2<=0x1F),
//    1-cycle latency; addr 6 -> 0x00.
//  6 Assert reset_n mid-tone, and a write coincident with psg_en ->
//    reset values immediately; old period used in the coincident cycle.

Source files
------------

// File: rtl/psg_channel.sv
// rtl/psg_channel.sv - AY-style tone/noise channel with mixer, volume and register readback
// Counters and LFSR only move on psg_en; register writes apply every clock.
module psg_channel #(
  parameter int          TONE_W    = 12,
  parameter int          NOISE_W   = 5,
  parameter int          VOL_W     = 4,
  parameter logic [16:0] LFSR_SEED = 17'h00001
) (
  input  logic             clk_peripheral,
  input  logic             reset_n,
  input  logic             psg_en,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [2:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             tone_out,
  output logic             noise_out,
  output logic [VOL_W-1:0] audio_out
);

  logic [TONE_W-1:0]  tone_r;
  logic [NOISE_W-1:0] noise_p;
  logic               tone_dis;
  logic               noise_dis;
  logic [VOL_W-1:0]   vol_r;

  logic [TONE_W-1:0]  tcnt;
  logic [NOISE_W-1:0] ncnt;
  logic               presc;
  logic [16:0]        lfsr;

  logic [TONE_W-1:0]  tone_eff;
  logic [TONE_W:0]    tcnt_inc;
  logic               tone_wrap;
  logic [NOISE_W-1:0] noise_eff;
  logic [NOISE_W:0]   ncnt_inc;
  logic               noise_wrap;
  logic               mix_on;

  // A zero period behaves as 1; the >= compare also catches a period shrunk below the count.
  assign tone_eff   = (tone_r == '0) ? TONE_W'(1) : tone_r;
  assign tcnt_inc   = {1'b0, tcnt} + {{TONE_W{1'b0}}, 1'b1};
  assign tone_wrap  = tcnt_inc >= {1'b0, tone_eff};
  assign noise_eff  = (noise_p == '0) ? NOISE_W'(1) : noise_p;
  assign ncnt_inc   = {1'b0, ncnt} + {{NOISE_W{1'b0}}, 1'b1};
  assign noise_wrap = ncnt_inc >= {1'b0, noise_eff};
  assign noise_out  = lfsr[0];
  assign mix_on     = (tone_out | tone_dis) & (noise_out | noise_dis);

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      tone_r    <= '0;
      noise_p   <= '0;
      tone_dis  <= 1'b0;
      noise_dis <= 1'b0;
      vol_r     <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0: tone_r[7:0]        <= wr_data;
        3'd1: tone_r[TONE_W-1:8] <= wr_data[TONE_W-9:0];
        3'd2: noise_p            <= wr_data[NOISE_W-1:0];
        3'd3: begin
          tone_dis  <= wr_data[0];
          noise_dis <= wr_data[1];
        end
        3'd4: vol_r              <= wr_data[VOL_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      tcnt     <= '0;
      tone_out <= 1'b0;
    end else if (psg_en) begin
      if (tone_wrap) begin
        tcnt     <= '0;
        tone_out <= ~tone_out;
      end else begin
        tcnt <= tcnt_inc[TONE_W-1:0];
      end
    end
  end

  // Noise runs at half the tick rate via a 1-bit prescaler; it steps when presc was set.
  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      presc <= 1'b0;
      ncnt  <= '0;
      lfsr  <= LFSR_SEED;
    end else if (psg_en) begin
      presc <= ~presc;
      if (presc) begin
        if (noise_wrap) begin
          ncnt <= '0;
          lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end else begin
          ncnt <= ncnt_inc[NOISE_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      audio_out <= '0;
      rd_data   <= '0;
    end else begin
      audio_out <= mix_on ? vol_r : '0;
      case (rd_addr)
        3'd0:    rd_data <= tone_r[7:0];
        3'd1:    rd_data <= 8'(tone_r[TONE_W-1:8]);
        3'd2:    rd_data <= 8'(noise_p);
        3'd3:    rd_data <= {6'b0, noise_dis, tone_dis};
        3'd4:    rd_data <= 8'(vol_r);
        default: rd_data <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_channel.sv
// tb/tb_psg_channel.sv - directed self-checking bench for psg_channel
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_psg_channel;

  logic       clk_peripheral;
  logic       reset_n;
  logic       psg_en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       tone_out;
  logic       noise_out;
  logic [3:0] audio_out;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] div;
  logic       psg_run;
  logic       fast;
  logic       last_tick;
  logic       e_tone;
  logic [16:0] m_lfsr;
  logic       m_presc;
  logic       prev_bit;
  logic [7:0] rd_exp [8];
  logic [7:0] rd_prev;

  psg_channel dut (
    .clk_peripheral (clk_peripheral),
    .reset_n        (reset_n),
    .psg_en         (psg_en),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .tone_out       (tone_out),
    .noise_out      (noise_out),
    .audio_out      (audio_out)
  );

  initial clk_peripheral = 1'b0;
  always #5 clk_peripheral = ~clk_peripheral;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: psg_en is a 16-clock strobe, or every clock in fast mode.
  task automatic step();
    psg_en = psg_run && (fast || div == 4'd15);
    last_tick = psg_en;
    @(posedge clk_peripheral);
    #1;
    div = div + 4'd1;
    psg_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic tick_sync();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!last_tick && k < 32);
    if (!last_tick) check("tick_timeout", 32'(last_tick), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; psg_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; psg_run = 1'b0; fast = 1'b0; div = '0; last_tick = 1'b0;
    repeat (3) @(posedge clk_peripheral);
    #1;
    check("rst_tone",  32'(tone_out),  32'd0);
    check("rst_noise", 32'(noise_out), 32'd1);
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_rd",    32'(rd_data),   32'd0);
    reset_n = 1'b1;
    step();

    // Tone period 1, noise disabled, full volume.
    wr(3'd0, 8'd1); wr(3'd1, 8'd0); wr(3'd3, 8'h02); wr(3'd4, 8'h0F);
    div = '0; psg_run = 1'b1; e_tone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_sync();
      e_tone = ~e_tone;
      check("t1_tone", 32'(tone_out), 32'(e_tone));
      step();
      check("t1_audio", 32'(audio_out), e_tone ? 32'hF : 32'h0);
    end

    // Period 0 behaves like period 1.
    psg_run = 1'b0; wr(3'd0, 8'd0); psg_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_sync();
      e_tone = ~e_tone;
      check("t2_tone0", 32'(tone_out), 32'(e_tone));
    end

    // Period 0xFFF: toggle after exactly 4095 ticks.
    psg_run = 1'b0; wr(3'd0, 8'hFF); wr(3'd1, 8'h0F);
    fast = 1'b1; psg_run = 1'b1;
    repeat (4094) step();
    check("t2_fff_hold", 32'(tone_out), 32'(e_tone));
    step();
    e_tone = ~e_tone;
    check("t2_fff_toggle", 32'(tone_out), 32'(e_tone));

    // Period 100 run to count 50, then shrunk to 10: wraps on the next tick.
    psg_run = 1'b0; wr(3'd0, 8'd100); wr(3'd1, 8'd0); psg_run = 1'b1;
    repeat (50) step();
    check("t2_p100_hold", 32'(tone_out), 32'(e_tone));
    psg_run = 1'b0; wr(3'd0, 8'd10); psg_run = 1'b1;
    step();
    e_tone = ~e_tone;
    check("t2_shrink_wrap", 32'(tone_out), 32'(e_tone));
    repeat (9) step();
    check("t2_p10_hold", 32'(tone_out), 32'(e_tone));
    step();
    e_tone = ~e_tone;
    check("t2_p10_toggle", 32'(tone_out), 32'(e_tone));

    // Noise: period 1, tone disabled, volume 8, against a reference LFSR.
    psg_run = 1'b0;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    wr(3'd2, 8'd1); wr(3'd3, 8'h01); wr(3'd4, 8'h08); step();
    m_lfsr = 17'h00001; m_presc = 1'b0; psg_run = 1'b1;
    for (int i = 0; i < 24; i++) begin
      prev_bit = m_lfsr[0];
      step();
      if (m_presc) m_lfsr = {m_lfsr[0] ^ m_lfsr[3], m_lfsr[16:1]};
      m_presc = ~m_presc;
      check("t3_noise", 32'(noise_out), 32'(m_lfsr[0]));
      check("t3_audio", 32'(audio_out), prev_bit ? 32'h8 : 32'h0);
    end

    // Both sources disabled: DC level, and volume follows two clocks after wr_en.
    wr(3'd3, 8'h03); wr(3'd4, 8'h05);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t4_dc", 32'(audio_out), 32'h5);
    end
    wr(3'd4, 8'h09);
    check("t4_vol_old", 32'(audio_out), 32'h5);
    step();
    check("t4_vol_new", 32'(audio_out), 32'h9);

    // Readback with zero-extension, ignored high addresses, 1-cycle latency.
    psg_run = 1'b0;
    wr(3'd0, 8'hA5); wr(3'd1, 8'hFC); wr(3'd2, 8'hFF); wr(3'd3, 8'hFE);
    wr(3'd4, 8'h37); wr(3'd5, 8'hFF); wr(3'd7, 8'h12);
    rd_exp = '{8'hA5, 8'h0C, 8'h1F, 8'h02, 8'h07, 8'h00, 8'h00, 8'h00};
    rd_prev = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      rd_addr = 3'(i % 8);
      #1;
      check("t5_rd_latency", 32'(rd_data), 32'(rd_prev));
      step();
      check("t5_rd", 32'(rd_data), 32'(rd_exp[i % 8]));
      rd_prev = rd_exp[i % 8];
    end

    // Asynchronous reset mid-tone.
    wr(3'd0, 8'd1); wr(3'd1, 8'd0); wr(3'd3, 8'h03); wr(3'd4, 8'h0F);
    fast = 1'b1; psg_run = 1'b1;
    step();
    if (!tone_out) step();
    check("t6_pre_tone", 32'(tone_out), 32'd1);
    check("t6_pre_audio", 32'(audio_out), 32'hF);
    rd_addr = 3'd0;
    reset_n = 1'b0;
    #1;
    check("t6_rst_tone",  32'(tone_out),  32'd0);
    check("t6_rst_noise", 32'(noise_out), 32'd1);
    check("t6_rst_audio", 32'(audio_out), 32'd0);
    check("t6_rst_rd",    32'(rd_data),   32'd0);
    psg_run = 1'b0;
    step();
    reset_n = 1'b1;
    rd_addr = 3'd4;
    step();
    check("t6_rst_vol", 32'(rd_data), 32'd0);

    // Write coincident with psg_en: that tick still compares against period 3.
    wr(3'd0, 8'd3);
    psg_run = 1'b1;
    step();
    check("t6_tick1", 32'(tone_out), 32'd0);
    wr(3'd0, 8'd1);
    check("t6_coincident", 32'(tone_out), 32'd0);
    step();
    check("t6_new_period", 32'(tone_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
